// File: rtl/panda_if_stage.sv
// Instruction fetch stage: holds the architectural PC, fetches one word at a time over a
// req/gnt/rvalid bus and selects the next PC from the datapath redirect inputs.
module panda_if_stage #(
   parameter logic [31:0] BootAddr = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_inc_o,
   input  logic        instr_ready_i,
   input  logic        jump_i,
   input  logic        branch_i,
   input  logic        branch_cond_i,
   input  logic [31:0] jump_target_i,
   output logic        fetch_err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_VALID,
      S_FAULT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_inc;
   logic [31:0] redirect;
   logic [31:0] pc_next;
   logic        take;

   assign pc_inc   = pc_q + 32'd4;
   assign redirect = jump_target_i & ~32'd1;
   // jump_i dominates; a branch only redirects when its condition holds
   assign take     = jump_i | (branch_i & branch_cond_i);
   assign pc_next  = take ? redirect : pc_inc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         pc_q    <= BootAddr;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         S_IDLE:  state_d = S_REQ;
         S_REQ: begin
            if (instr_gnt_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (instr_rvalid_i) begin
               if (instr_err_i) begin
                  state_d = S_FAULT;
               end else begin
                  instr_d = instr_rdata_i;
                  state_d = S_VALID;
               end
            end
         end
         S_VALID: begin
            // a misaligned target faults and leaves pc at the redirecting instruction
            if (instr_ready_i) begin
               if (pc_next[1]) begin
                  state_d = S_FAULT;
               end else begin
                  pc_d    = pc_next;
                  state_d = S_REQ;
               end
            end
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_IDLE;
      endcase
   end

   assign instr_req_o   = (state_q == S_REQ);
   assign instr_addr_o  = pc_q;
   assign instr_valid_o = (state_q == S_VALID);
   assign instr_o       = instr_q;
   assign pc_o          = pc_q;
   assign pc_inc_o      = pc_inc;
   assign fetch_err_o   = (state_q == S_FAULT);

endmodule

// File: tb/tb_panda_if_stage.sv
// Bench for panda_if_stage: redirect vector table, directed corner sequences and
// randomized fetch/retire traffic against a transaction-level PC model.
module tb_panda_if_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req, valid, ferr;
   logic [31:0] addr, instr, pc, pc_inc;
   logic        gnt = 1'b0, rvalid = 1'b0, berr = 1'b0, ready = 1'b0;
   logic        jmp = 1'b0, br = 1'b0, cond = 1'b0;
   logic [31:0] rdata = '0, tgt = '0;

   int unsigned checks = 0;
   int unsigned failures = 0;

   panda_if_stage #(.BootAddr(32'h0000_0000)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .instr_req_o(req), .instr_addr_o(addr), .instr_gnt_i(gnt),
      .instr_rvalid_i(rvalid), .instr_rdata_i(rdata), .instr_err_i(berr),
      .instr_valid_o(valid), .instr_o(instr), .pc_o(pc), .pc_inc_o(pc_inc),
      .instr_ready_i(ready), .jump_i(jmp), .branch_i(br), .branch_cond_i(cond),
      .jump_target_i(tgt), .fetch_err_o(ferr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      logic        j, b, c;
      logic [31:0] target;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic j,
                                            input logic b, input logic c, input logic [31:0] t);
      if (j || (b && c)) return {t[31:1], 1'b0};
      return cur + 32'd4;
   endfunction

   task automatic clear_inputs();
      gnt = 0; rvalid = 0; berr = 0; ready = 0; jmp = 0; br = 0; cond = 0;
      rdata = '0; tgt = '0;
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_req"}, {31'd0, req}, 32'd0);
      chk({nm, "_valid"}, {31'd0, valid}, 32'd0);
      chk({nm, "_err"}, {31'd0, ferr}, 32'd0);
      chk({nm, "_pc"}, pc, 32'h0);
      chk({nm, "_pcinc"}, pc_inc, 32'h4);
      chk({nm, "_instr"}, instr, 32'h0);
   endtask

   // Leaves the DUT in its first request cycle at BootAddr.
   task automatic reset_and_start();
      clear_inputs();
      rst_n = 0;
      tick();
      tick();
      check_reset_vals("rst");
      rst_n = 1;
      check_reset_vals("idle");
      tick();
   endtask

   // Issue one fetch: gd extra gnt wait cycles, rd extra rvalid wait cycles.
   task automatic fetch(input logic [31:0] a, input int unsigned gd, input int unsigned rd,
                        input logic [31:0] d, input logic e);
      for (int unsigned g = 0; g < gd; g++) begin
         chk("stall_req", {31'd0, req}, 32'd1);
         chk("stall_addr", addr, a);
         chk("stall_valid", {31'd0, valid}, 32'd0);
         tick();
      end
      chk("req", {31'd0, req}, 32'd1);
      chk("addr", addr, a);
      gnt = 1;
      tick();
      gnt = 0;
      for (int unsigned r = 0; r <= rd; r++) begin
         chk("wait_req", {31'd0, req}, 32'd0);
         chk("wait_valid", {31'd0, valid}, 32'd0);
         if (r == rd) begin
            rvalid = 1; rdata = d; berr = e;
         end
         tick();
      end
      rvalid = 0; berr = 0; rdata = $urandom;
   endtask

   task automatic expect_valid(input logic [31:0] p, input logic [31:0] d);
      chk("valid", {31'd0, valid}, 32'd1);
      chk("instr", instr, d);
      chk("pc", pc, p);
      chk("pc_inc", pc_inc, p + 32'd4);
      chk("valid_req", {31'd0, req}, 32'd0);
   endtask

   // Fault must persist regardless of bus activity.
   task automatic expect_fault(input logic [31:0] p);
      for (int unsigned k = 0; k < 3; k++) begin
         chk("fault_err", {31'd0, ferr}, 32'd1);
         chk("fault_valid", {31'd0, valid}, 32'd0);
         chk("fault_req", {31'd0, req}, 32'd0);
         chk("fault_pc", pc, p);
         gnt = 1; rvalid = 1; ready = 1; rdata = $urandom;
         tick();
      end
      clear_inputs();
   endtask

   // Retire the current instruction; returns whether the model predicts a fault.
   task automatic retire(input logic [31:0] cur, input logic j, input logic b, input logic c,
                         input logic [31:0] t, output logic [31:0] nxt, output logic flt);
      nxt = ref_next(cur, j, b, c, t);
      flt = nxt[1];
      ready = 1; jmp = j; br = b; cond = c; tgt = t;
      tick();
      ready = 0; jmp = $urandom; br = $urandom; cond = $urandom; tgt = $urandom;
      if (flt) begin
         expect_fault(cur);
      end else begin
         chk("next_req", {31'd0, req}, 32'd1);
         chk("next_addr", addr, nxt);
      end
   endtask

   logic [31:0] mpc, nxt, d, t, hold_instr;
   logic        flt, e, j, b, c;

   initial begin
      vecs[0] = '{32'h100, 1'b1, 1'b0, 1'b0, 32'h200, 32'h200};
      vecs[1] = '{32'h100, 1'b0, 1'b1, 1'b0, 32'h080, 32'h104};
      vecs[2] = '{32'h100, 1'b0, 1'b1, 1'b1, 32'h080, 32'h080};
      vecs[3] = '{32'h100, 1'b1, 1'b1, 1'b0, 32'h300, 32'h300};
      vecs[4] = '{32'h100, 1'b0, 1'b0, 1'b1, 32'h040, 32'h104};
      vecs[5] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h500, 32'h000};
      vecs[6] = '{32'h010, 1'b1, 1'b0, 1'b0, 32'h021, 32'h020};
      vecs[7] = '{32'h010, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFD, 32'h7FFF_FFFC};

      // reset release and zero-wait first fetch
      reset_and_start();
      fetch(32'h0, 0, 0, 32'h0000_0013, 1'b0);
      expect_valid(32'h0, 32'h13);

      // sequential fetches, second one with a 2-cycle gnt stall
      retire(32'h0, 0, 0, 0, 32'h0, nxt, flt);
      fetch(32'h4, 2, 0, 32'hAAAA_0004, 1'b0);
      expect_valid(32'h4, 32'hAAAA_0004);
      retire(32'h4, 0, 0, 0, 32'h0, nxt, flt);
      fetch(32'h8, 0, 1, 32'hAAAA_0008, 1'b0);
      expect_valid(32'h8, 32'hAAAA_0008);

      // ready low for 4 cycles with bus noise: nothing moves
      for (int unsigned k = 0; k < 4; k++) begin
         rvalid = ~rvalid; rdata = $urandom; gnt = $urandom;
         tick();
         chk("hold_instr", instr, 32'hAAAA_0008);
         chk("hold_pc", pc, 32'h8);
         chk("hold_valid", {31'd0, valid}, 32'd1);
         chk("hold_req", {31'd0, req}, 32'd0);
      end
      clear_inputs();

      // redirect table
      mpc = 32'h8;
      for (int unsigned i = 0; i < 8; i++) begin
         retire(mpc, 1'b1, 1'b0, 1'b0, vecs[i].base, nxt, flt);
         fetch(vecs[i].base, 0, 0, ~vecs[i].base, 1'b0);
         expect_valid(vecs[i].base, ~vecs[i].base);
         ready = 1; jmp = vecs[i].j; br = vecs[i].b; cond = vecs[i].c; tgt = vecs[i].target;
         tick();
         clear_inputs();
         chk($sformatf("vec%0d_req", i), {31'd0, req}, 32'd1);
         chk($sformatf("vec%0d_addr", i), addr, vecs[i].exp_next);
         fetch(vecs[i].exp_next, 0, 0, 32'h1234_5678, 1'b0);
         expect_valid(vecs[i].exp_next, 32'h1234_5678);
         mpc = vecs[i].exp_next;
      end

      // misaligned redirect -> sticky fault at retiring pc
      retire(mpc, 1'b1, 1'b0, 1'b0, 32'h200, nxt, flt);
      fetch(32'h200, 0, 0, 32'h6F, 1'b0);
      expect_valid(32'h200, 32'h6F);
      ready = 1; jmp = 1; tgt = 32'h0000_0206;
      tick();
      clear_inputs();
      expect_fault(32'h200);

      // bus error -> sticky fault at fetch pc
      reset_and_start();
      fetch(32'h0, 1, 1, 32'hDEAD_BEEF, 1'b1);
      expect_fault(32'h0);

      // reset while waiting for rvalid; stale response afterwards ignored
      reset_and_start();
      fetch(32'h0, 0, 0, 32'h13, 1'b0);
      retire(32'h0, 0, 0, 0, 32'h0, nxt, flt);
      gnt = 1;
      tick();
      gnt = 0;
      rst_n = 0;
      #1;
      check_reset_vals("async_rst");
      tick();
      tick();
      check_reset_vals("async_hold");
      rst_n = 1;
      rvalid = 1; rdata = 32'hBAD0_BAD0;
      tick();
      rvalid = 0;
      chk("restart_req", {31'd0, req}, 32'd1);
      chk("restart_addr", addr, 32'h0);
      chk("restart_valid", {31'd0, valid}, 32'd0);
      fetch(32'h0, 0, 0, 32'h0000_0033, 1'b0);
      expect_valid(32'h0, 32'h33);

      // randomized traffic against the PC model
      reset_and_start();
      mpc = 32'h0;
      for (int unsigned i = 0; i < 200; i++) begin
         e = ($urandom_range(0, 29) == 0);
         d = $urandom;
         fetch(mpc, $urandom_range(0, 2), $urandom_range(0, 2), d, e);
         if (e) begin
            expect_fault(mpc);
            reset_and_start();
            mpc = 32'h0;
            continue;
         end
         expect_valid(mpc, d);
         hold_instr = d;
         for (int unsigned k = $urandom_range(0, 2); k > 0; k--) begin
            rvalid = $urandom; rdata = $urandom; jmp = $urandom; br = $urandom;
            tick();
            chk("rnd_hold", instr, hold_instr);
            chk("rnd_hold_pc", pc, mpc);
         end
         clear_inputs();
         j = $urandom; b = $urandom; c = $urandom;
         t = $urandom;
         if ($urandom_range(0, 7) != 0) t[1] = 1'b0;
         if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
         retire(mpc, j, b, c, t, nxt, flt);
         if (flt) begin
            reset_and_start();
            mpc = 32'h0;
         end else begin
            mpc = nxt;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL timeout: simulation did not finish, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/panda_if_stage.md
Name: panda_if_stage

Overview:
- Instruction fetch stage directly upstream of panda_sc_datapath.
- Holds the architectural PC and fetches one instruction at a time from instruction memory over a req/gnt/rvalid bus.
- Presents pc, pc+4 and the instruction word to the controller/datapath.
- Consumes the datapath's jump_target and branch_cond to select the next PC. One outstanding request maximum.

Parameters:
- BootAddr, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  word-aligned fetch address (= pc_o)
- instr_gnt_i  in  1  request accepted
- instr_rvalid_i  in  1  read data valid
- instr_rdata_i  in  32  read data
- instr_err_i  in  1  bus error, qualified by instr_rvalid_i
- instr_valid_o  out  1  instr_o/pc_o valid for execution
- instr_o  out  32  fetched instruction
- pc_o  out  32  PC of instr_o
- pc_inc_o  out  32  pc_o + 4, combinational, modulo 2^32
- instr_ready_i  in  1  core retires the current instruction this cycle
- jump_i  in  1  current instruction is JAL/JALR
- branch_i  in  1  current instruction is a conditional branch
- branch_cond_i  in  1  branch taken (datapath branch_cond)
- jump_target_i  in  32  redirect target (datapath jump_target, bit 0 already 0)
- fetch_err_o  out  1  sticky fault: bus error or misaligned target

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, pc=BootAddr, instr=0.
  - instr_req_o=0, instr_valid_o=0, fetch_err_o=0.
  - pc_inc_o=BootAddr+4.
- FSM states: IDLE, REQ, WAIT, VALID, FAULT.
- IDLE: outputs idle; next cycle -> REQ unconditionally (first request one cycle after reset release).
- REQ:
  - instr_req_o=1, instr_addr_o=pc.
  - req and addr held stable until gnt.
  - gnt=1 -> WAIT; else stay.
- WAIT:
  - instr_req_o=0.
  - rvalid=1 and err=0 -> capture rdata into instr, go to VALID.
  - rvalid=1 and err=1 -> FAULT.
  - Otherwise stay. rvalid arrives no earlier than the cycle after gnt; rvalid outside WAIT is ignored.
- VALID:
  - instr_valid_o=1; instr_o/pc_o stable while instr_ready_i=0.
  - On instr_ready_i=1, next pc:
    - jump_i=1 -> jump_target_i
    - else branch_i=1 and branch_cond_i=1 -> jump_target_i
    - else pc+4
  - jump_i has priority when jump_i and branch_i are both 1.
  - If the selected next pc has bit 1 set -> FAULT, pc unchanged. Otherwise -> REQ with pc updated.
  - jump/branch inputs are sampled only when instr_valid_o and instr_ready_i are both 1.
- FAULT:
  - fetch_err_o=1, instr_valid_o=0, instr_req_o=0.
  - pc holds the faulting fetch PC (bus error) or the PC of the redirecting instruction (misaligned).
  - Exit only by reset.
- Timing: zero-wait memory (gnt in the REQ cycle, rvalid the next cycle) -> REQ, WAIT, VALID = 3 cycles minimum per instruction. Each extra gnt or rvalid wait cycle adds 1.
- Arithmetic: pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no fault.
- Bit 0 of jump_target_i is forced to 0 internally.
- Reset mid-transaction: state returns to IDLE immediately; the pending memory response is discarded. The memory shares the same reset.

Test Plan:
- Reset release, BootAddr=0x0, gnt same cycle, rvalid next cycle with rdata=0x00000013 -> req at 0x0 one cycle after reset; instr_valid_o=1 on the 3rd cycle after reset with instr_o=0x13, pc_o=0x0, pc_inc_o=0x4.
- Sequential fetch with instr_ready_i=1 each valid cycle, gnt delayed 2 cycles on the second fetch -> addresses 0x0, 0x4, 0x8; addr stable and req held during the stall; 5-cycle gap on the stalled fetch.
- In VALID at pc=0x100: jump_i=1 with target 0x200 -> next req to 0x200. Branch with cond=0 -> 0x104. Branch with cond=1, target 0x80 -> 0x80.
- Hold instr_ready_i=0 for 4 cycles in VALID, toggling instr_rdata_i and rvalid -> instr_o/pc_o unchanged; no request issued.
- jump_target_i=0x00000206 on retire -> FAULT; fetch_err_o=1, no further req, pc_o=retiring PC. rvalid with instr_err_i=1 -> FAULT. Both cleared only by reset.
- Assert rst_ni=0 while in WAIT, deassert 2 cycles later -> outputs at reset values during reset; fetch restarts at BootAddr; the stale rvalid is ignored. pc=0xFFFFFFFC sequential retire -> next fetch at 0x0.
